// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer: channel FSM encoding, default timing
// constants and the counter-width helper used to size the per-channel counters.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int         DEF_DEBOUNCE_CYCLES = 250000;    // 10 ms at 25 MHz
    localparam int         DEF_LONG_CYCLES     = 25000000;  // 1 s at 25 MHz
    localparam logic [6:0] DEF_INV_MASK        = 7'b0000001;

    // Bits needed to hold the values 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One button channel: optional inversion, 2-flop synchroniser, debounce FSM and long-press timer.
// Latency 2 + DEBOUNCE_CYCLES cycles from raw edge to o_btn; no backpressure, pulses last one cycle.
module debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter bit INV             = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic raw,
    output logic o_btn,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int             DCW       = cnt_width(DEBOUNCE_CYCLES);
    localparam int             LCW       = cnt_width(LONG_CYCLES + 1);
    localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LCW-1:0] LONG_MAX  = LCW'(LONG_CYCLES);
    localparam logic [LCW-1:0] LONG_LAST = LCW'(LONG_CYCLES - 1);

    logic [1:0]     sync_q;
    logic           s;
    btn_state_e     state_q, state_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic [LCW-1:0] lcnt_q, lcnt_d;
    logic           btn_d, press_d, release_d, long_d;

    assign s = sync_q[1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q    <= 2'b00;
            state_q   <= IDLE;
            dcnt_q    <= '0;
            lcnt_q    <= '0;
            o_btn     <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_long    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], raw ^ INV};
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            lcnt_q    <= lcnt_d;
            o_btn     <= btn_d;
            o_press   <= press_d;
            o_release <= release_d;
            o_long    <= long_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        lcnt_d    = lcnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        case (state_q)
            IDLE: begin
                lcnt_d = '0;
                if (s) begin
                    state_d = PRESS_WAIT;
                    dcnt_d  = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    dcnt_d  = '0;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            PRESSED: begin
                // Saturating timer: LONG_LAST is passed exactly once per accepted press.
                if (LONG_CYCLES > 0) begin
                    long_d = (lcnt_q == LONG_LAST);
                    if (lcnt_q != LONG_MAX) lcnt_d = lcnt_q + 1'b1;
                end
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    dcnt_d  = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = PRESSED;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    lcnt_d    = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A bounce during release keeps the level asserted until the release is accepted.
    assign btn_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);

endmodule

// File: rtl/btn_debounce.sv
// NBTN independent debounced button channels with press, release and long-press pulses.
// Latency 2 + DEBOUNCE_CYCLES cycles per channel; no backpressure, all outputs registered.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int              NBTN            = 7,
    parameter int              DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int              LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter logic [NBTN-1:0] INV_MASK        = NBTN'(DEF_INV_MASK)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [NBTN-1:0] btn,
    output logic [NBTN-1:0] o_btn,
    output logic [NBTN-1:0] o_press,
    output logic [NBTN-1:0] o_release,
    output logic [NBTN-1:0] o_long
);

    for (genvar i = 0; i < NBTN; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .INV            (INV_MASK[i])
        ) u_ch (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .raw      (btn[i]),
            .o_btn    (o_btn[i]),
            .o_press  (o_press[i]),
            .o_release(o_release[i]),
            .o_long   (o_long[i])
        );
    end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 The module SHALL have parameter NBTN, default 7, the number of button channels.
REQ-002 The module SHALL have parameter DEBOUNCE_CYCLES, default 250000 (10 ms at 25 MHz), the stable-sample count required before a level change is accepted; legal range 1..2^24.
REQ-003 The module SHALL have parameter LONG_CYCLES, default 25000000 (1 s), the hold time before the long-press pulse; 0 disables long-press.
REQ-004 The module SHALL have parameter INV_MASK, default 7'b0000001, where a set bit marks that raw input as active-low and inverts it before synchronisation.
REQ-005 i_clk  input  1  system clock; all state is on its rising edge.
REQ-006 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 btn  input  NBTN  raw asynchronous button pins.
REQ-008 o_btn  output  NBTN  debounced level, 1 = pressed.
REQ-009 o_press  output  NBTN  one-cycle pulse on each accepted press.
REQ-010 o_release  output  NBTN  one-cycle pulse on each accepted release.
REQ-011 o_long  output  NBTN  one-cycle pulse when a press has been held LONG_CYCLES cycles.

Function
REQ-012 Each channel SHALL XOR its raw bit with INV_MASK and pass it through a 2-flop synchroniser; the second flop output is the sample s.
REQ-013 Each channel SHALL run an FSM with states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT and a debounce counter.
REQ-014 IDLE: s=1 -> PRESS_WAIT with the counter cleared; otherwise stay.
REQ-015 PRESS_WAIT: s=0 -> IDLE, counter cleared, no pulse; s=1 with counter = DEBOUNCE_CYCLES-1 -> PRESSED; otherwise increment.
REQ-016 On entry to PRESSED from PRESS_WAIT, o_btn SHALL rise and o_press SHALL pulse for exactly that first cycle.
REQ-017 PRESSED: s=0 -> RELEASE_WAIT with the debounce counter cleared; the long counter increments each PRESSED cycle and saturates at LONG_CYCLES.
REQ-018 o_long SHALL pulse for exactly one cycle when the long counter reaches LONG_CYCLES-1, at most once per accepted press.
REQ-019 RELEASE_WAIT: s=1 -> PRESSED with no pulse and the long counter preserved; s=0 with counter = DEBOUNCE_CYCLES-1 -> IDLE; otherwise increment; the long counter holds.
REQ-020 On entry to IDLE from RELEASE_WAIT, o_btn SHALL fall and o_release SHALL pulse for one cycle; the long counter clears.
REQ-021 Total latency SHALL be 2 synchroniser cycles + DEBOUNCE_CYCLES from a clean raw edge to the o_btn change.
REQ-022 Any glitch shorter than DEBOUNCE_CYCLES samples SHALL produce no change on any output.
REQ-023 Channels SHALL be fully independent, and simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-024 Counters SHALL be sized from the parameters (clog2) and SHALL never wrap.
REQ-025 o_press, o_release and o_long SHALL never be asserted together on one channel.

Reset
REQ-026 While i_rst_n=0, all FSMs SHALL be IDLE, all counters 0, synchroniser flops 0, and o_btn, o_press, o_release and o_long all 0.
REQ-027 Reset asserted mid-press SHALL clear immediately with no release pulse, and after deassertion a still-held button SHALL require a full debounce before o_press.
REQ-028 Reset deassertion SHALL be synchronised to i_clk by the integrating top level.

Structure
REQ-029 The shared package btn_pkg SHALL hold the FSM state encoding and the default DEBOUNCE_CYCLES, LONG_CYCLES and INV_MASK constants.
REQ-030 The channel logic (synchroniser, FSM, two counters) SHALL be a sub-module debounce_ch, instantiated NBTN times by btn_debounce in a generate loop.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=16, INV_MASK=0)
REQ-031 Clean press: btn[1] 0->1 and held -> o_btn[1]=1 and a single o_press[1] pulse exactly 6 cycles after the edge.
REQ-032 Bounce: btn[2] toggles 1,0,1,0 every 2 cycles, then stays 1 -> no output until 6 cycles after the final rise, then one o_press[2].
REQ-033 Long hold: btn[3] held 30 cycles -> one o_press[3], one o_long[3] 16 cycles later, no second o_long, and on release one o_release[3] 6 cycles after the fall.
REQ-034 Release glitch: while pressed, btn[4] drops for 2 cycles -> o_btn[4] stays 1 with no pulses.
REQ-035 Reset mid-press: pull i_rst_n low during PRESSED -> all outputs 0 at once with no o_release, and with the button still held, o_press reappears 6 cycles after deassertion.
REQ-036 Inversion: INV_MASK=7'b0000001, btn[0] driven 1->0 -> o_btn[0] rises 6 cycles later, and all 7 channels pressed together pulse in the same cycle.
